// File: rtl/wash_input_cond_pkg.sv
// Shared defaults and input channel indices for the wash input conditioner and controller.
// Pure declarations, so there is no latency and no backpressure.
package wash_input_cond_pkg;

  localparam int DB_CYCLES_DEF   = 500000;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int N_CH            = 4;

  typedef enum logic [1:0] {
    CH_START = 2'd0,
    CH_FULL  = 2'd1,
    CH_COLD  = 2'd2,
    CH_EMPTY = 2'd3
  } ch_e;

endpackage

// File: rtl/wash_debounce_cell.sv
// One input channel: a SYNC_STAGES-flop synchroniser followed by a saturating debounce counter.
// Latency SYNC_STAGES+DB_CYCLES cycles from a stable raw change to o_q; there is no backpressure.
module wash_debounce_cell
  import wash_input_cond_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_q
);

  localparam int            CW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_q;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign o_q    = r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // Any return to the stable level restarts the count, so only an unbroken run is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_q   <= 1'b0;
    end else if (w_sync == r_q) begin
      r_cnt <= '0;
    end else if (r_cnt == TERM) begin
      r_q   <= w_sync;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wash_input_cond.sv
// Debounces start/full/cold/empty and makes a ready-gated start pulse; no backpressure.
// Level latency SYNC_STAGES+DB_CYCLES; define WASH_INTERLOCK_EN for the full/empty interlock.
module wash_input_cond
  import wash_input_cond_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start_btn,
  input  logic full_sw,
  input  logic cold_sw,
  input  logic empty_sw,
  input  logic ready,
  output logic start,
  output logic full,
  output logic cold,
  output logic empty,
  output logic sensor_flt
);

  logic [N_CH-1:0] w_raw;
  logic [N_CH-1:0] w_q;
  logic            r_start_d;

  assign w_raw[CH_START] = start_btn;
  assign w_raw[CH_FULL]  = full_sw;
  assign w_raw[CH_COLD]  = cold_sw;
  assign w_raw[CH_EMPTY] = empty_sw;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    wash_debounce_cell #(
      .DB_CYCLES  (DB_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_cell (
      .i_clk  (clk),
      .i_rst_n(reset),
      .i_raw  (w_raw[g]),
      .o_q    (w_q[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start_d <= 1'b0;
    end else begin
      r_start_d <= w_q[CH_START];
    end
  end

  // A press that arrives while the controller is busy is dropped, never queued.
  assign start = w_q[CH_START] & ~r_start_d & ready;
  assign cold  = w_q[CH_COLD];

`ifdef WASH_INTERLOCK_EN
  logic r_flt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flt <= 1'b0;
    end else begin
      r_flt <= w_q[CH_FULL] & w_q[CH_EMPTY];
    end
  end

  assign sensor_flt = r_flt;
  assign full       = w_q[CH_FULL]  & ~r_flt;
  assign empty      = w_q[CH_EMPTY] & ~r_flt;
`else
  assign sensor_flt = 1'b0;
  assign full       = w_q[CH_FULL];
  assign empty      = w_q[CH_EMPTY];
`endif

endmodule

// File: tb/tb_wash_input_cond.sv
// Bench for wash_input_cond with DB_CYCLES=8, SYNC_STAGES=2: sliding-window model plus directed checks.
module tb_wash_input_cond;
  import wash_input_cond_pkg::*;

  localparam int DB = 8;
  localparam int SS = 2;
  localparam int HL = SS + DB;
  localparam int IS = int'(CH_START);
  localparam int IF = int'(CH_FULL);
  localparam int IC = int'(CH_COLD);
  localparam int IE = int'(CH_EMPTY);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_btn = 1'b1, full_sw = 1'b1, cold_sw = 1'b1, empty_sw = 1'b1, ready = 1'b1;
  logic start, full, cold, empty, sensor_flt;

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  wash_input_cond #(.DB_CYCLES(DB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .full_sw(full_sw),
    .cold_sw(cold_sw), .empty_sw(empty_sw), .ready(ready), .start(start),
    .full(full), .cold(cold), .empty(empty), .sensor_flt(sensor_flt)
  );

  // Model: a level flips once the last DB raw samples seen through the synchroniser all disagree with it.
  bit hist [4][HL];
  bit mq [4];
  bit m_start_prev;
  bit m_flt;

  function automatic bit raw_of(int c);
    case (c)
      IS:      return start_btn;
      IF:      return full_sw;
      IC:      return cold_sw;
      default: return empty_sw;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    bit flip;
    if (!reset) begin
      for (int c = 0; c < 4; c++) begin
        mq[c] = 1'b0;
        for (int k = 0; k < HL; k++) hist[c][k] = 1'b0;
      end
      m_start_prev = 1'b0;
      m_flt = 1'b0;
    end else begin
      m_flt = mq[IF] & mq[IE];
      m_start_prev = mq[IS];
      for (int c = 0; c < 4; c++) begin
        flip = 1'b1;
        for (int k = SS - 1; k <= SS + DB - 2; k++)
          if (hist[c][k] == mq[c]) flip = 1'b0;
        if (flip) mq[c] = ~mq[c];
        for (int k = HL - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = raw_of(c);
      end
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_start", start, mq[IS] & ~m_start_prev & ready);
      chk("model_cold", cold, mq[IC]);
`ifdef WASH_INTERLOCK_EN
      chk("model_full", full, mq[IF] & ~m_flt);
      chk("model_empty", empty, mq[IE] & ~m_flt);
      chk("model_flt", sensor_flt, m_flt);
`else
      chk("model_full", full, mq[IF]);
      chk("model_empty", empty, mq[IE]);
      chk("model_flt", sensor_flt, 1'b0);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic count_start(input int n, output int cnt, output int at);
    cnt = 0;
    at = -1;
    for (int i = 1; i <= n; i++) begin
      step(1);
      if (start === 1'b1) begin
        cnt++;
        if (at < 0) at = i;
      end
    end
  endtask

  initial begin
    int cnt, at;
    // Reset held with every raw input high
    step(3);
    cmp_en = 1'b1;
    chk("rst_start", start, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_cold", cold, 1'b0);
    chk("rst_empty", empty, 1'b0);
    chk("rst_flt", sensor_flt, 1'b0);
    reset = 1'b1;
    step(9);
    chk("rel_full_c9", full, 1'b0);
    chk("rel_cold_c9", cold, 1'b0);
    step(1);
    chk("rel_full_c10", full, 1'b1);
    chk("rel_cold_c10", cold, 1'b1);
    chk("rel_empty_c10", empty, 1'b1);
    chk("rel_start_c10", start, 1'b1);
    step(1);
    chk("rel_start_c11", start, 1'b0);
    {start_btn, full_sw, cold_sw, empty_sw} = 4'b0000;
    step(20);

    // Glitch rejection, then a clean rise
    full_sw = 1'b1;
    step(5);
    full_sw = 1'b0;
    step(20);
    chk("glitch_full", full, 1'b0);
    full_sw = 1'b1;
    step(9);
    chk("rise_full_c9", full, 1'b0);
    step(1);
    chk("rise_full_c10", full, 1'b1);
    step(10);
    full_sw = 1'b0;
    step(20);

    // One pulse per debounced press
    ready = 1'b1;
    start_btn = 1'b1;
    count_start(50, cnt, at);
    chk("press1_one_pulse", cnt == 1, 1'b1);
    chk("press1_at_c10", at == 10, 1'b1);
    start_btn = 1'b0;
    step(20);
    start_btn = 1'b1;
    count_start(20, cnt, at);
    chk("press2_one_pulse", cnt == 1, 1'b1);
    start_btn = 1'b0;
    step(20);

    // Press while busy is dropped
    ready = 1'b0;
    start_btn = 1'b1;
    count_start(15, cnt, at);
    chk("busy_no_pulse", cnt == 0, 1'b1);
    ready = 1'b1;
    count_start(15, cnt, at);
    chk("late_ready_no_pulse", cnt == 0, 1'b1);
    start_btn = 1'b0;
    step(20);

    // Independent channels, cold bounces once
    full_sw = 1'b1;
    step(3);
    cold_sw = 1'b1;
    step(1);
    cold_sw = 1'b0;
    step(1);
    cold_sw = 1'b1;
    step(5);
    chk("indep_full_c10", full, 1'b1);
    chk("indep_cold_c10", cold, 1'b0);
    step(4);
    chk("indep_cold_c14", cold, 1'b0);
    step(1);
    chk("indep_cold_c15", cold, 1'b1);

    // Full and empty together
    empty_sw = 1'b1;
    step(10);
`ifdef WASH_INTERLOCK_EN
    chk("ilk_first_full", full, 1'b1);
    chk("ilk_first_flt", sensor_flt, 1'b0);
    step(1);
    chk("ilk_flt_set", sensor_flt, 1'b1);
    chk("ilk_full_masked", full, 1'b0);
    chk("ilk_empty_masked", empty, 1'b0);
`else
    step(1);
    chk("both_full", full, 1'b1);
    chk("both_empty", empty, 1'b1);
    chk("both_flt", sensor_flt, 1'b0);
`endif
    empty_sw = 1'b0;
    step(10);
`ifdef WASH_INTERLOCK_EN
    chk("ilk_hold_flt", sensor_flt, 1'b1);
    chk("ilk_hold_full", full, 1'b0);
    step(1);
    chk("ilk_clr_flt", sensor_flt, 1'b0);
    chk("ilk_clr_full", full, 1'b1);
`else
    chk("drop_empty", empty, 1'b0);
    chk("drop_full", full, 1'b1);
`endif
    full_sw = 1'b0;
    cold_sw = 1'b0;
    step(20);

    // Reset mid-debounce discards the partial count
    cold_sw = 1'b1;
    step(5);
    reset = 1'b0;
    step(2);
    chk("midrst_cold", cold, 1'b0);
    reset = 1'b1;
    step(9);
    chk("midrst_cold_c9", cold, 1'b0);
    step(1);
    chk("midrst_cold_c10", cold, 1'b1);
    step(3);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
